timer_entry_loader: RTL and testbench
=====================================

Name: timer_entry_loader

Overview:
- Keypad-side driver for the down-counting MM:SS timer chain.
- Collects decimal digits microwave-style, right-shifting them into four BCD digit registers.
- On start, issues the parallel `load` and then holds the timer's active-low count enable.
- Stops the count when the timer reports zero and raises an alarm for a fixed number of cycles.

Parameters:
- ALARM_CYCLES, 8, number of cycles `alarm` stays high in DONE (minimum 1).
- CNT_W, 4, width of the alarm cycle counter; must satisfy 2^CNT_W > ALARM_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
- key_code  input  4  keypad digit; values 0-9 accepted, 10-15 ignored.
- start_key  input  1  one-cycle start strobe.
- clear_key  input  1  one-cycle clear/pause strobe.
- timer_zero  input  1  high when every timer digit is 0 (derived from the timer's active-low ripple carry outputs).
- min_tens  output  4  load data, minutes tens digit.
- min_ones  output  4  load data, minutes ones digit.
- sec_tens  output  4  load data, seconds tens digit (0-9 allowed; the timer counts 60-99 down).
- sec_ones  output  4  load data, seconds ones digit.
- load  output  1  one-cycle parallel-load strobe to all timer digits.
- enablen  output  1  active-low count enable to the timer chain.
- alarm  output  1  high while in DONE.
- fsm_state  output  3  current state encoding, for debug/display.

Behaviour:
- Reset (rst=0, asynchronous), all outputs forced immediately:
  - state IDLE; all four digits 0; internal digit_count 0.
  - load=0, enablen=1, alarm=0, alarm counter 0.
- States and encodings: IDLE=0, ENTRY=1, LOADING=2, RUNNING=3, PAUSED=4, DONE=5. Codes 6-7 recover to IDLE on the next edge.
- Same-cycle priority: clear_key > start_key > key_valid. Lower-priority events in the same cycle are dropped.
- Digit accept (IDLE or ENTRY, key_valid=1, key_code<=9):
  - Shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code.
  - digit_count increments.
  - State becomes ENTRY.
- Digit-entry boundaries:
  - When digit_count=4, further digits are ignored; no shift and no wrap.
  - key_code>9 is ignored in every state.
  - Digits in LOADING, RUNNING, PAUSED or DONE are ignored.
- IDLE transitions:
  - start_key ignored.
  - clear_key leaves state unchanged with digits at 0.
- ENTRY transitions:
  - start_key goes to LOADING.
  - clear_key zeroes all digits and digit_count, then goes to IDLE.
- LOADING: exactly one cycle.
  - load=1, enablen=1.
  - Next state RUNNING unconditionally.
  - The timer captures the digits on the same edge that leaves LOADING.
- RUNNING: enablen=0, load=0; digit registers hold their values.
  - timer_zero=1 sampled goes to DONE. The check is active from the first RUNNING cycle, so an all-zero entry (e.g. "0") reaches DONE one cycle after LOADING.
  - clear_key goes to PAUSED; clear has priority over timer_zero in the same cycle.
- PAUSED: enablen=1.
  - start_key returns to RUNNING with no reload.
  - clear_key zeroes digits and digit_count, then goes to IDLE.
- DONE: enablen=1, alarm=1.
  - Alarm counter counts from 0 up to ALARM_CYCLES-1; on that final cycle, next state is IDLE with digits and digit_count cleared.
  - clear_key in DONE goes to IDLE immediately.
  - start_key is ignored in DONE.
- Output timing:
  - load, enablen and alarm are registered and decoded from state only (Moore), valid the cycle after the transition edge.
  - No combinational input-to-output paths.
- Reset asserted mid-LOADING or mid-RUNNING forces enablen=1 and load=0 without waiting for a clock edge.

Test Plan:
- Reset then keys 1,3,0 then start → digits 0,1,3,0; one cycle with load=1; then enablen=0; timer_zero raised 5 cycles later → alarm=1 for exactly 8 cycles, then IDLE with digits 0000.
- Keys 9,9,9,9,5 → digits stay 9999 (5th digit ignored); key_code=12 → no change; start → load with 99:99.
- Key 0, start → LOADING, RUNNING; timer_zero=1 → DONE on the next edge, alarm=1.
- RUNNING; clear_key → enablen=1 (PAUSED), no load; start_key → enablen=0 with no load pulse; clear, clear → IDLE, digits 0000.
- Same cycle: key_valid (7) + start_key in ENTRY → LOADING without shifting 7; clear_key + start_key in ENTRY → IDLE.
- rst=0 asserted asynchronously mid-RUNNING (between edges) → enablen=1, alarm=0, digits 0 immediately; after release, start_key ignored in IDLE.

Source files
------------

// File: rtl/timer_entry_loader_if.sv
// Keypad/timer-side bundle for timer_entry_loader: key strobes and timer status in,
// load data, load strobe, count enable, alarm and debug state out.
interface timer_entry_loader_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_key;
    logic       clear_key;
    logic       timer_zero;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       load;
    logic       enablen;
    logic       alarm;
    logic [2:0] fsm_state;

    modport master (
        output key_valid, key_code, start_key, clear_key, timer_zero,
        input  min_tens, min_ones, sec_tens, sec_ones, load, enablen, alarm, fsm_state
    );

    modport slave (
        input  key_valid, key_code, start_key, clear_key, timer_zero,
        output min_tens, min_ones, sec_tens, sec_ones, load, enablen, alarm, fsm_state
    );
endinterface

// File: rtl/timer_entry_loader.sv
// Microwave-style MM:SS entry for the down-counting timer chain: shifts digits in,
// pulses load on start, gates the count enable and sounds a timed alarm at zero.
module timer_entry_loader #(
    parameter int ALARM_CYCLES = 8,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    timer_entry_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        LOADING = 3'd2,
        RUNNING = 3'd3,
        PAUSED  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [2:0]       digit_count;
    logic [CNT_W-1:0] alarm_count;
    logic [15:0]      digits;
    logic             shift_digit;
    logic             clear_digits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority is clear > start > digit; a strobe that loses is simply dropped.
    always_comb begin
        next_state   = state;
        shift_digit  = 1'b0;
        clear_digits = 1'b0;
        case (state)
            IDLE, ENTRY: begin
                if (bus.clear_key) begin
                    clear_digits = 1'b1;
                    next_state   = IDLE;
                end else if (bus.start_key) begin
                    if (state == ENTRY) begin
                        next_state = LOADING;
                    end
                end else if (bus.key_valid && (bus.key_code <= 4'd9) && (digit_count < 3'd4)) begin
                    shift_digit = 1'b1;
                    next_state  = ENTRY;
                end
            end
            LOADING: next_state = RUNNING;
            RUNNING: begin
                if (bus.clear_key) begin
                    next_state = PAUSED;
                end else if (bus.timer_zero) begin
                    next_state = DONE;
                end
            end
            PAUSED: begin
                if (bus.clear_key) begin
                    clear_digits = 1'b1;
                    next_state   = IDLE;
                end else if (bus.start_key) begin
                    next_state = RUNNING;
                end
            end
            DONE: begin
                if (bus.clear_key || (alarm_count == ALARM_LAST)) begin
                    clear_digits = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.load      = (state == LOADING);
        bus.enablen   = (state != RUNNING);
        bus.alarm     = (state == DONE);
        bus.fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits      <= 16'h0000;
            digit_count <= 3'd0;
        end else if (clear_digits) begin
            digits      <= 16'h0000;
            digit_count <= 3'd0;
        end else if (shift_digit) begin
            digits      <= {digits[11:0], bus.key_code};
            digit_count <= digit_count + 3'd1;
        end
    end

    // Counts alarm cycles while DONE persists; any exit leaves it ready at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_count <= '0;
        end else if ((state == DONE) && (next_state == DONE)) begin
            alarm_count <= alarm_count + 1'b1;
        end else begin
            alarm_count <= '0;
        end
    end

    assign bus.min_tens = digits[15:12];
    assign bus.min_ones = digits[11:8];
    assign bus.sec_tens = digits[7:4];
    assign bus.sec_ones = digits[3:0];

endmodule

// File: tb/tb_timer_entry_loader.sv
// Self-checking bench for timer_entry_loader: directed scenarios with literal
// expectations, then randomized keys compared every cycle against a reference model.
module tb_timer_entry_loader;

    localparam int ALARM_CYCLES = 8;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_LOADING = 2, S_RUNNING = 3, S_PAUSED = 4, S_DONE = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total_checks = 0;
    int   passed_checks = 0;
    bit   cmp_en = 1'b0;

    int          m_state = S_IDLE;
    logic [15:0] m_digits = 16'h0000;
    int          m_count = 0;
    int          m_alarm_idx = 0;

    timer_entry_loader_if bus ();

    timer_entry_loader #(.ALARM_CYCLES(ALARM_CYCLES), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, lets one rising edge consume them, then returns just after it.
    task automatic applyStimulus(input bit kv, input int kc, input bit st, input bit cl, input bit tz);
        @(negedge clk);
        bus.key_valid  = kv;
        bus.key_code   = 4'(kc);
        bus.start_key  = st;
        bus.clear_key  = cl;
        bus.timer_zero = tz;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic key(input int k);
        applyStimulus(1, k, 0, 0, 0);
    endtask

    // Reference model: the entered time as a 16-bit BCD word that new digits push in from the right.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = S_IDLE; m_digits = 16'h0000; m_count = 0; m_alarm_idx = 0;
        end else begin
            case (m_state)
                S_IDLE, S_ENTRY: begin
                    if (bus.clear_key) begin
                        m_state = S_IDLE; m_digits = 16'h0000; m_count = 0;
                    end else if (bus.start_key) begin
                        if (m_state == S_ENTRY) m_state = S_LOADING;
                    end else if (bus.key_valid && bus.key_code <= 9 && m_count < 4) begin
                        m_digits = (m_digits << 4) | 16'(bus.key_code);
                        m_count++;
                        m_state = S_ENTRY;
                    end
                end
                S_LOADING: m_state = S_RUNNING;
                S_RUNNING: begin
                    if (bus.clear_key) m_state = S_PAUSED;
                    else if (bus.timer_zero) begin
                        m_state = S_DONE; m_alarm_idx = 0;
                    end
                end
                S_PAUSED: begin
                    if (bus.clear_key) begin
                        m_state = S_IDLE; m_digits = 16'h0000; m_count = 0;
                    end else if (bus.start_key) m_state = S_RUNNING;
                end
                default: begin
                    if (bus.clear_key || m_alarm_idx == ALARM_CYCLES - 1) begin
                        m_state = S_IDLE; m_digits = 16'h0000; m_count = 0;
                    end else m_alarm_idx++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("digits", int'(dut_digits()), int'(m_digits));
            checkOutput("state", int'(bus.fsm_state), m_state);
            checkOutput("load", int'(bus.load), int'(m_state == S_LOADING));
            checkOutput("enablen", int'(bus.enablen), int'(m_state != S_RUNNING));
            checkOutput("alarm", int'(bus.alarm), int'(m_state == S_DONE));
        end
    end

    initial begin
        int alarm_seen;
        bus.key_valid = 0; bus.key_code = 0; bus.start_key = 0; bus.clear_key = 0; bus.timer_zero = 0;
        rst = 1'b0;
        #1;
        checkOutput("reset_enablen", int'(bus.enablen), 1);
        checkOutput("reset_load", int'(bus.load), 0);
        checkOutput("reset_digits", int'(dut_digits()), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;

        // 1,3,0 then start; timer reaches zero; alarm runs its full length
        key(1); key(3); key(0);
        checkOutput("entry_130", int'(dut_digits()), 16'h0130);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("load_pulse", int'(bus.load), 1);
        checkOutput("loading_enablen", int'(bus.enablen), 1);
        idle(1);
        checkOutput("load_dropped", int'(bus.load), 0);
        checkOutput("running_enablen", int'(bus.enablen), 0);
        idle(4);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("done_alarm", int'(bus.alarm), 1);
        alarm_seen = 0;
        for (int i = 0; i < 20 && bus.alarm; i++) begin
            alarm_seen++;
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("alarm_cycles", alarm_seen, ALARM_CYCLES);
        checkOutput("after_alarm_state", int'(bus.fsm_state), S_IDLE);
        checkOutput("after_alarm_digits", int'(dut_digits()), 0);

        // Full entry, overflow digit and invalid code ignored; then pause/resume
        key(9); key(9); key(9); key(9); key(5);
        checkOutput("entry_full", int'(dut_digits()), 16'h9999);
        key(12);
        checkOutput("entry_badcode", int'(dut_digits()), 16'h9999);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("load_9999", int'(bus.load), 1);
        checkOutput("load_data_9999", int'(dut_digits()), 16'h9999);
        idle(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("paused_state", int'(bus.fsm_state), S_PAUSED);
        checkOutput("paused_enablen", int'(bus.enablen), 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("resume_noload", int'(bus.load), 0);
        checkOutput("resume_enablen", int'(bus.enablen), 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("clear_idle", int'(bus.fsm_state), S_IDLE);
        checkOutput("clear_digits", int'(dut_digits()), 0);

        // All-zero entry reaches DONE one cycle after LOADING
        key(0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("zero_running", int'(bus.fsm_state), S_RUNNING);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("zero_done", int'(bus.alarm), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("done_clear", int'(bus.fsm_state), S_IDLE);

        // Same-cycle priority in ENTRY
        key(3);
        applyStimulus(1, 7, 1, 0, 0);
        checkOutput("start_beats_key", int'(bus.fsm_state), S_LOADING);
        checkOutput("start_noshift", int'(dut_digits()), 16'h0003);
        idle(1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        key(4);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("clear_beats_start", int'(bus.fsm_state), S_IDLE);

        // Asynchronous reset mid-RUNNING
        key(5);
        applyStimulus(0, 0, 1, 0, 0);
        idle(1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_enablen", int'(bus.enablen), 1);
        checkOutput("async_alarm", int'(bus.alarm), 0);
        checkOutput("async_digits", int'(dut_digits()), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("idle_start_ignored", int'(bus.fsm_state), S_IDLE);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 35), int'($urandom_range(0, 15)),
                          ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 5),
                          ($urandom_range(0, 99) < 12));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
